// File: rtl/dds_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel DDS sine source.
// Quarter-wave table entries are computed in fixed point so the table is a pure constant.
package dds_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  function automatic int midscale(input int sine_w);
    return 1 << (sine_w - 1);
  endfunction

  function automatic int amplitude(input int sine_w);
    return (1 << (sine_w - 1)) - 1;
  endfunction

  // round(amplitude * sin(pi/2 * (k+0.5) / 2^lut_aw)), via a Taylor series in Q30 fixed point.
  function automatic int quarter_sine(input int k, input int sine_w, input int lut_aw);
    longint half_pi;
    longint x;
    longint x2;
    longint term;
    longint sum;
    half_pi = 64'sd1686629713;
    x       = (half_pi * longint'(2 * k + 1)) >>> (lut_aw + 1);
    x2      = (x * x) >>> 30;
    term    = x;
    sum     = x;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((longint'(amplitude(sine_w)) * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dds_multi_sine_if.sv
// Control and sample-stream bundle of dds_multi_sine; the generator is the master side.
interface dds_multi_sine_if #(
  parameter int SINE_W  = 8,
  parameter int PHASE_W = 16,
  parameter int NUM_CH  = 2
);
  logic                      enable;
  logic                      sync;
  logic [PHASE_W-1:0]        freq_word;
  logic [NUM_CH*PHASE_W-1:0] phase_off;
  logic                      out_ready;
  logic                      out_valid;
  logic [NUM_CH*SINE_W-1:0]  sine;
  logic                      wrap;

  modport master (
    input  enable, sync, freq_word, phase_off, out_ready,
    output out_valid, sine, wrap
  );

  modport slave (
    output enable, sync, freq_word, phase_off, out_ready,
    input  out_valid, sine, wrap
  );
endinterface

// File: rtl/quarter_sine_rom.sv
// Shared quarter-wave sine table with NUM_CH read ports; the registered, sign-folded
// lookup is the output stage of the DDS pipeline.
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int SINE_W = 8,
  parameter int LUT_AW = 6,
  parameter int NUM_CH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NUM_CH*LUT_AW-1:0] addr,
  input  logic [NUM_CH-1:0]        neg,
  output logic [NUM_CH*SINE_W-1:0] sine
);

  localparam int DEPTH = 2 ** LUT_AW;
  localparam logic [SINE_W-1:0] MID = SINE_W'(midscale(SINE_W));

  logic [SINE_W-1:0] table_q [DEPTH];

  // NOTE: the table is elaboration constants rather than storage, so it takes no reset.
  for (genvar k = 0; k < DEPTH; k++) begin : g_table
    localparam int ENTRY = quarter_sine(k, SINE_W, LUT_AW);
    assign table_q[k] = SINE_W'(ENTRY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sine <= {NUM_CH{MID}};
    end else if (load) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sine[c*SINE_W +: SINE_W] <= neg[c] ? MID - table_q[addr[c*LUT_AW +: LUT_AW]]
                                           : MID + table_q[addr[c*LUT_AW +: LUT_AW]];
      end
    end
  end

endmodule

// File: rtl/dds_multi_sine.sv
// Multi-channel DDS sine generator: phase accumulator, per-channel offsets, one shared
// quarter-wave table, valid/ready output. Optional phase dither: define DDS_DITHER_EN.
module dds_multi_sine
  import dds_pkg::*;
#(
  parameter int SINE_W  = 8,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int NUM_CH  = 2
) (
  input logic               clock,
  input logic               reset,
  dds_multi_sine_if.master  stream
);

  localparam int TRUNC_W = PHASE_W - LUT_AW - 2;

  logic [PHASE_W-1:0]       acc;
  logic                     acc_wrap;
  logic [PHASE_W:0]         acc_sum;
  logic                     s1_valid;
  logic                     s1_wrap;
  logic [NUM_CH*LUT_AW-1:0] s1_addr;
  logic [NUM_CH-1:0]        s1_neg;
  logic [NUM_CH*LUT_AW-1:0] addr_next;
  logic [NUM_CH-1:0]        neg_next;
  logic                     out_valid;
  logic                     out_wrap;
  logic                     advance;
  logic                     load;
  logic [PHASE_W-1:0]       dither;

  // A presented sample that is not taken freezes the whole pipeline.
  assign advance = stream.enable & ~(out_valid & ~stream.out_ready);
  assign load    = advance & ~stream.sync;
  assign acc_sum = {1'b0, acc} + {1'b0, stream.freq_word};

`ifdef DDS_DITHER_EN
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] DITHER_MASK = 16'((32'd1 << TRUNC_W) - 32'd1);

  logic [15:0] lfsr;

  assign dither = PHASE_W'(lfsr & DITHER_MASK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (stream.sync) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end
`else
  assign dither = '0;
`endif

  // Quadrant folding: odd quadrants read the table backwards, the lower half is negated.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_phase
    logic [LUT_AW+1:0] phase_top;
    quadrant_e         quad;
    logic [LUT_AW-1:0] idx;

    assign phase_top = (LUT_AW + 2)'((acc + stream.phase_off[c*PHASE_W +: PHASE_W] + dither)
                                     >> TRUNC_W);
    assign quad      = quadrant_e'(phase_top[LUT_AW+1 -: 2]);
    assign idx       = phase_top[LUT_AW-1:0];
    assign addr_next[c*LUT_AW +: LUT_AW] = (quad == Q1 || quad == Q3) ? ~idx : idx;
    assign neg_next[c]                   = (quad == Q2 || quad == Q3);
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_wrap  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_wrap   <= 1'b0;
      s1_addr   <= '0;
      s1_neg    <= '0;
      out_valid <= 1'b0;
      out_wrap  <= 1'b0;
    end else if (stream.sync) begin
      acc       <= '0;
      acc_wrap  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_wrap   <= 1'b0;
      out_valid <= 1'b0;
      out_wrap  <= 1'b0;
    end else if (advance) begin
      acc       <= acc_sum[PHASE_W-1:0];
      acc_wrap  <= acc_sum[PHASE_W];
      s1_valid  <= 1'b1;
      s1_wrap   <= acc_wrap;
      s1_addr   <= addr_next;
      s1_neg    <= neg_next;
      out_valid <= s1_valid;
      out_wrap  <= s1_wrap;
    end
  end

  quarter_sine_rom #(
    .SINE_W (SINE_W),
    .LUT_AW (LUT_AW),
    .NUM_CH (NUM_CH)
  ) u_rom (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .addr  (s1_addr),
    .neg   (s1_neg),
    .sine  (stream.sine)
  );

  assign stream.out_valid = out_valid;
  assign stream.wrap      = out_wrap;

endmodule

// File: tb/tb_dds_multi_sine.sv
// Self-checking bench for dds_multi_sine (default build, two channels, 8-bit samples).
// Reference: beat n has phase n*freq_word + offset, sampled on a 256-point full sine period.
module tb_dds_multi_sine;

  localparam real PI = 3.14159265358979323846;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  dds_multi_sine_if #(.SINE_W(8), .PHASE_W(16), .NUM_CH(2)) bus ();

  dds_multi_sine #(
    .SINE_W  (8),
    .PHASE_W (16),
    .LUT_AW  (6),
    .NUM_CH  (2)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .stream (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full-period sine at the truncated 8-bit phase, centred on 128 with amplitude 127.
  function automatic logic [7:0] ref_sample(input longint phase);
    longint n;
    real    v;
    int     r;
    n = (phase % 65536) / 256;
    v = 127.0 * $sin(2.0 * PI * (real'(n) + 0.5) / 256.0);
    r = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    return 8'(128 + r);
  endfunction

  // {wrap, ch1, ch0} of beat n since the last sync.
  function automatic logic [16:0] ref_beat(input longint n, input longint f,
                                           input longint o0, input longint o1);
    longint a;
    logic   w;
    a = (n * f) % 65536;
    w = (n > 0) && (((n * f) >> 16) != (((n - 1) * f) >> 16));
    return {w, ref_sample(a + o1), ref_sample(a + o0)};
  endfunction

  task automatic start_stream(input logic [15:0] f, input logic [15:0] o0, input logic [15:0] o1);
    @(posedge clock); #1;
    bus.freq_word = f;
    bus.phase_off = {o1, o0};
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    bus.sync      = 1'b1;
    @(posedge clock); #1;
    bus.sync      = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b0;
    bus.freq_word = '0; bus.phase_off = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #12;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.sine !== 16'h8080) $display("FAIL reset_sine: got %h expected 8080", bus.sine);
    else n_pass++;
    n_checks++;
    if (bus.wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", bus.wrap);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.sine !== 16'h8080)
      $display("FAIL idle_disabled: got valid=%b sine=%h expected valid=0 sine=8080",
               bus.out_valid, bus.sine);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int ch0_seq [4];
    ch0_seq = '{130, 255, 126, 1};
    bus.freq_word = 16'd16384;
    bus.phase_off = {16'd16384, 16'd0};
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.enable = 1'b1;
    @(posedge clock); @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL latency_1: got valid=%b expected 0", bus.out_valid);
    else n_pass++;
    @(posedge clock); @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clock); @(negedge clock);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL sweep_valid beat %0d: got %b expected 1", i, bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.sine[7:0] !== 8'(ch0_seq[i % 4]))
        $display("FAIL sweep_ch0 beat %0d: got %0d expected %0d", i, bus.sine[7:0], ch0_seq[i % 4]);
      else n_pass++;
      n_checks++;
      if (bus.sine[15:8] !== 8'(ch0_seq[(i + 1) % 4]))
        $display("FAIL sweep_ch1 beat %0d: got %0d expected %0d", i, bus.sine[15:8], ch0_seq[(i + 1) % 4]);
      else n_pass++;
      n_checks++;
      if (bus.wrap !== ((i % 4 == 0) && (i > 0)))
        $display("FAIL sweep_wrap beat %0d: got %b expected %b", i, bus.wrap, (i % 4 == 0) && (i > 0));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int          beat;
    logic [16:0] exp;
    logic [16:0] held;
    beat = 0;
    start_stream(16'd16384, 16'd0, 16'd16384);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) begin
        exp = ref_beat(beat, 16384, 0, 16384);
        n_checks++;
        if ({bus.wrap, bus.sine} !== exp)
          $display("FAIL stall_pre beat %0d: got %h expected %h", beat, {bus.wrap, bus.sine}, exp);
        else n_pass++;
        beat++;
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b0;
    @(negedge clock);
    held = {bus.out_valid, bus.sine};
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL stall_valid: got %b expected 1", bus.out_valid);
    else n_pass++;
    repeat (4) begin
      @(posedge clock); #1;
      @(negedge clock);
      n_checks++;
      if ({bus.out_valid, bus.sine} !== held)
        $display("FAIL stall_hold: got %h expected %h", {bus.out_valid, bus.sine}, held);
      else n_pass++;
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) begin
        exp = ref_beat(beat, 16384, 0, 16384);
        n_checks++;
        if ({bus.wrap, bus.sine} !== exp)
          $display("FAIL stall_post beat %0d: got %h expected %h", beat, {bus.wrap, bus.sine}, exp);
        else n_pass++;
        beat++;
      end
      @(posedge clock); #1;
    end
    n_checks++;
    if (beat != 14) $display("FAIL stall_count: got %0d beats expected 14", beat);
    else n_pass++;
  endtask

  task automatic test_sync();
    int waited;
    start_stream(16'd16384, 16'd0, 16'd16384);
    repeat (6) @(posedge clock);
    #1 bus.out_ready = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL sync_prestall: got valid=%b expected 1", bus.out_valid);
    else n_pass++;
    @(posedge clock); #1 bus.sync = 1'b1;
    @(posedge clock); #1 bus.sync = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL sync_drop: got valid=%b expected 0", bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b1;
    waited = 0;
    while (!bus.out_valid && waited < 10) begin
      @(posedge clock); @(negedge clock);
      waited++;
    end
    n_checks++;
    if (waited != 2) $display("FAIL sync_latency: got %0d cycles expected 2", waited);
    else n_pass++;
    n_checks++;
    if (bus.sine[7:0] !== 8'd130 || bus.wrap !== 1'b0)
      $display("FAIL sync_first: got ch0=%0d wrap=%b expected ch0=130 wrap=0", bus.sine[7:0], bus.wrap);
    else n_pass++;
  endtask

  task automatic test_dc();
    logic [15:0] o1;
    o1 = 16'($urandom);
    start_stream(16'd0, 16'd32768, o1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.sine[7:0] !== 8'd126 || bus.wrap !== 1'b0)
          $display("FAIL dc_ch0 cycle %0d: got valid=%b ch0=%0d wrap=%b expected 1/126/0",
                   i, bus.out_valid, bus.sine[7:0], bus.wrap);
        else n_pass++;
        n_checks++;
        if (bus.sine[15:8] !== ref_sample(longint'(o1)))
          $display("FAIL dc_ch1 cycle %0d: got %0d expected %0d", i, bus.sine[15:8], ref_sample(longint'(o1)));
        else n_pass++;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    logic [15:0] f;
    logic [15:0] o0;
    logic [15:0] o1;
    logic [16:0] exp;
    int          beat;
    for (int r = 0; r < 6; r++) begin
      f  = (r == 0) ? 16'hFFFF : 16'($urandom);
      o0 = 16'($urandom);
      o1 = 16'($urandom);
      beat = 0;
      start_stream(f, o0, o1);
      for (int i = 0; i < 80; i++) begin
        bus.out_ready = ($urandom_range(99) < 70);
        @(negedge clock);
        if (bus.out_valid && bus.out_ready) begin
          exp = ref_beat(beat, longint'(f), longint'(o0), longint'(o1));
          n_checks++;
          if ({bus.wrap, bus.sine} !== exp)
            $display("FAIL random run %0d beat %0d: got %h expected %h (f=%h o0=%h o1=%h)",
                     r, beat, {bus.wrap, bus.sine}, exp, f, o0, o1);
          else n_pass++;
          beat++;
        end
        @(posedge clock); #1;
      end
      n_checks++;
      if (beat < 20) $display("FAIL random_progress run %0d: got %0d beats expected at least 20", r, beat);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    start_stream(16'd16384, 16'd0, 16'd16384);
    repeat (8) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.sine !== 16'h8080 || bus.wrap !== 1'b0)
      $display("FAIL midstream_reset: got valid=%b sine=%h wrap=%b expected 0/8080/0",
               bus.out_valid, bus.sine, bus.wrap);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); @(posedge clock); @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sine[7:0] !== 8'd130)
      $display("FAIL midstream_restart: got valid=%b ch0=%0d expected 1/130", bus.out_valid, bus.sine[7:0]);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_sweep();
    test_stall();
    test_sync();
    test_dc();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
